// File: rtl/tb_mem_access_seq_if.sv
// Request/response and memory-side signal bundle for tb_mem_access_seq.
// slave = sequencer side, master = requester plus memory side.
interface tb_mem_access_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_sz;
  logic              req_we;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_sz;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  acc_count;

  modport slave (
    input  req_valid, req_addr, req_wdata,
    input  req_sz, req_we, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, mem_addr, mem_wdata,
    output mem_sz, mem_we, acc_count
  );

  modport master (
    output req_valid, req_addr, req_wdata,
    output req_sz, req_we, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, mem_addr, mem_wdata,
    input  mem_sz, mem_we, acc_count
  );
endinterface

// File: rtl/tb_mem_access_seq.sv
// Single-outstanding load/store sequencer for the alternate-edge memory.
// Optional TB_MEM_ACC_ALIGN_CHECK_EN rejects misaligned 16-bit requests.
module tb_mem_access_seq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic reset,
  tb_mem_access_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD0,
    S_HOLD1,
    S_CAPT,
    S_ERR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_sz;
  logic              r_we;
  logic              r_mem_we;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_accept;
  logic              w_misalign;
  logic [DATA_W-1:0] w_load;

`ifdef TB_MEM_ACC_ALIGN_CHECK_EN
  logic r_err;
  assign w_misalign = bus.req_sz & bus.req_addr[0];
  assign bus.resp_err = r_err;
`else
  assign w_misalign = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) & bus.req_valid;

  assign w_load = r_sz ? bus.mem_rdata
                : {{(DATA_W-8){1'b0}}, bus.mem_rdata[7:0]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid)
          w_next = w_misalign ? S_ERR : S_HOLD0;
      end
      S_HOLD0: w_next = S_HOLD1;
      S_HOLD1: w_next = S_CAPT;
      S_CAPT:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // mem_we drops at the HOLD1->CAPT edge so CAPT never writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_sz         <= 1'b0;
      r_we         <= 1'b0;
      r_mem_we     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_cnt        <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept && !w_misalign) begin
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        r_sz     <= bus.req_sz;
        r_we     <= bus.req_we;
        r_mem_we <= bus.req_we;
      end else if (r_state == S_HOLD1) begin
        r_mem_we <= 1'b0;
      end
      if (r_state == S_CAPT) begin
        r_resp_valid <= 1'b1;
        r_cnt        <= r_cnt + 1'b1;
        r_rdata      <= r_we ? '0 : w_load;
      end
      if (r_state == S_ERR) begin
        r_resp_valid <= 1'b1;
        r_rdata      <= '0;
      end
    end
  end

`ifdef TB_MEM_ACC_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= (r_state == S_ERR);
  end
`endif

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.mem_sz     = r_sz;
  assign bus.mem_we     = r_mem_we;
  assign bus.acc_count  = r_cnt;

endmodule
